// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave in front of a word-organised on-chip SRAM with little-endian byte lanes.
// Optional wait states are enabled by defining AHB_SLV_WAIT_EN; the default build is zero-wait.
module ahb_lite_sram_slave #(
  parameter int MEM_DEPTH   = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  state_t            state, state_nxt;
  logic              accept, illegal, done, can_take, load;
  logic [ADDR_W+1:0] addr_p1;
  logic              write_p1;
  logic [1:0]        size_p1;
  logic [3:0]        lanes;
  logic [31:0]       mem [MEM_DEPTH];
  logic              unused_ok;

  function automatic logic is_illegal(input logic [2:0] size, input logic [31:0] addr);
    logic bad;
    bad = (size > 3'd2);
    if (size == 3'd1 && addr[0]) bad = 1'b1;
    if (size == 3'd2 && addr[1:0] != 2'b00) bad = 1'b1;
    if (addr >= 32'(4 * MEM_DEPTH)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001 << a;
      2'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  assign accept  = HSEL & HREADY & HTRANS[1];
  assign illegal = is_illegal(HSIZE, HADDR);

`ifdef AHB_SLV_WAIT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt <= 8'd0;
    end else if (load && !illegal) begin
      wait_cnt <= 8'(WAIT_CYCLES);
    end else if (state == DATA && wait_cnt != 8'd0) begin
      wait_cnt <= wait_cnt - 8'd1;
    end
  end

  assign done = (wait_cnt == 8'd0);
`else
  assign done = 1'b1;
`endif

  // A new address phase is only taken when no data phase is still being extended.
  assign can_take = (state == IDLE) || (state == ERR2) || (state == DATA && done);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      IDLE, ERR2, DATA: begin
        if (state == ERR2) HRESP = 1'b1;
        if (state == DATA) HREADYOUT = done;
        if (can_take) begin
          if (accept) begin
            load      = 1'b1;
            state_nxt = illegal ? ERR1 : DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = ERR2;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address phase -> data phase
  always_ff @(posedge HCLK) begin
    if (load) begin
      addr_p1  <= HADDR[ADDR_W+1:0];
      write_p1 <= HWRITE;
      size_p1  <= HSIZE[1:0];
    end
  end

  // Data phase: write commit on the completion edge
  assign lanes = lane_mask(size_p1, addr_p1[1:0]);

  always_ff @(posedge HCLK) begin
    if (HRESETn && state == DATA && done && write_p1) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) mem[addr_p1[ADDR_W+1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA = (state == DATA && !write_p1) ? mem[addr_p1[ADDR_W+1:2]] : 32'd0;

  assign unused_ok = ^{HBURST, HTRANS[0], 1'(WAIT_CYCLES)};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed self-checking bench for ahb_lite_sram_slave (zero-wait build, wait-state build when AHB_SLV_WAIT_EN is defined).
module tb_ahb_lite_sram_slave;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'd0;
  logic [1:0]  HTRANS = T_IDLE;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic [2:0]  HBURST = 3'd1;
  logic        HREADY;
  logic [31:0] HWDATA = 32'd0;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        stall = 1'b0;
  int          total = 0;
  int          bad = 0;

  assign HREADY = HREADYOUT & ~stall;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave #(.MEM_DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr; HWDATA = wdata;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_ready", 32'(HREADYOUT), 32'd1);
    check("rst_resp", 32'(HRESP), 32'd0);
    check("rst_rdata", HRDATA, 32'd0);
    HRESETn = 1'b1;
    step(1, T_IDLE, 0, 2, 32'h0, 32'h0);
    check("idle_ready", 32'(HREADYOUT), 32'd1);
    check("idle_resp", 32'(HRESP), 32'd0);
    check("idle_rdata", HRDATA, 32'd0);

`ifdef AHB_SLV_WAIT_EN
    step(1, T_NSEQ, 1, 2, 32'h20, 32'h0);
    check("w_wait1", 32'(HREADYOUT), 32'd0);
    step(1, T_IDLE, 0, 2, 32'h0, 32'h1234_5678);
    check("w_wait2", 32'(HREADYOUT), 32'd0);
    step(1, T_NSEQ, 0, 2, 32'h20, 32'h1234_5678);
    check("w_done", 32'(HREADYOUT), 32'd1);
    step(1, T_NSEQ, 0, 2, 32'h20, 32'h1234_5678);
    check("r_wait1", 32'(HREADYOUT), 32'd0);
    check("r_wait_data", HRDATA, 32'h1234_5678);
    step(1, T_IDLE, 0, 2, 32'h0, 32'h0);
    check("r_wait2", 32'(HREADYOUT), 32'd0);
    step(1, T_IDLE, 0, 2, 32'h0, 32'h0);
    check("r_done", 32'(HREADYOUT), 32'd1);
    check("r_data", HRDATA, 32'h1234_5678);
    step(1, T_IDLE, 0, 2, 32'h0, 32'h0);
    check("r_after", HRDATA, 32'd0);
    step(1, T_NSEQ, 1, 2, 32'h20, 32'h0);
    step(1, T_IDLE, 0, 2, 32'h0, 32'hFFFF_FFFF);
    HRESETn = 1'b0;
    #1;
    check("rst_wait_ready", 32'(HREADYOUT), 32'd1);
    check("rst_wait_resp", 32'(HRESP), 32'd0);
    step(1, T_IDLE, 0, 2, 32'h0, 32'h0);
    HRESETn = 1'b1;
    step(1, T_NSEQ, 0, 2, 32'h20, 32'h0);
    step(1, T_IDLE, 0, 2, 32'h0, 32'h0);
    step(1, T_IDLE, 0, 2, 32'h0, 32'h0);
    check("rst_lost_write", HRDATA, 32'h1234_5678);
`else
    // Halfword writes then word read
    step(1, T_NSEQ, 1, 1, 32'h20, 32'h0);
    check("hw_ready", 32'(HREADYOUT), 32'd1);
    step(1, T_SEQ, 1, 1, 32'h22, 32'h0000_1234);
    step(1, T_NSEQ, 0, 2, 32'h20, 32'h5678_0000);
    check("hw_word", HRDATA, 32'h5678_1234);
    // Byte write into lane 1
    step(1, T_NSEQ, 1, 0, 32'h21, 32'h0);
    step(1, T_NSEQ, 0, 2, 32'h20, 32'h0000_AB00);
    check("byte_lane1", HRDATA, 32'h5678_AB34);

    // Back-to-back write then read
    step(1, T_NSEQ, 1, 2, 32'h5C, 32'h0);
    step(1, T_NSEQ, 0, 2, 32'h5C, 32'hDEAD_BEEF);
    check("b2b_ready", 32'(HREADYOUT), 32'd1);
    check("b2b_data", HRDATA, 32'hDEAD_BEEF);
    step(1, T_IDLE, 0, 2, 32'h0, 32'h0);
    check("b2b_idle", HRDATA, 32'd0);

    // Error: misaligned word read
    step(1, T_NSEQ, 0, 2, 32'h62, 32'h0);
    check("err_mis_r1", {30'd0, HREADYOUT, HRESP}, 32'b01);
    step(1, T_IDLE, 0, 2, 32'h0, 32'h0);
    check("err_mis_r2", {30'd0, HREADYOUT, HRESP}, 32'b11);
    step(1, T_IDLE, 0, 2, 32'h0, 32'h0);
    check("err_mis_end", {30'd0, HREADYOUT, HRESP}, 32'b10);
    // Error: HSIZE=3
    step(1, T_NSEQ, 0, 3, 32'h20, 32'h0);
    check("err_sz_1", {30'd0, HREADYOUT, HRESP}, 32'b01);
    step(1, T_IDLE, 0, 2, 32'h0, 32'h0);
    check("err_sz_2", {30'd0, HREADYOUT, HRESP}, 32'b11);
    // Error: out of range, and the last legal word
    step(1, T_NSEQ, 0, 2, 32'h400, 32'h0);
    check("err_rng_1", {30'd0, HREADYOUT, HRESP}, 32'b01);
    step(1, T_IDLE, 0, 2, 32'h0, 32'h0);
    check("err_rng_2", {30'd0, HREADYOUT, HRESP}, 32'b11);
    step(1, T_NSEQ, 0, 2, 32'h3FC, 32'h0);
    check("top_legal", {30'd0, HREADYOUT, HRESP}, 32'b10);
    // Misaligned write must not touch memory; new transfer taken in ERR2
    step(1, T_NSEQ, 1, 2, 32'h5E, 32'h0);
    check("err_wr_1", {30'd0, HREADYOUT, HRESP}, 32'b01);
    step(1, T_IDLE, 0, 2, 32'h0, 32'h1111_1111);
    check("err_wr_2", {30'd0, HREADYOUT, HRESP}, 32'b11);
    step(1, T_NSEQ, 0, 2, 32'h5C, 32'h1111_1111);
    check("err_wr_mem", HRDATA, 32'hDEAD_BEEF);
    check("err_wr_okay", {30'd0, HREADYOUT, HRESP}, 32'b10);

    // Master stall: address phase ignored while HREADY is low
    step(1, T_NSEQ, 1, 2, 32'h30, 32'h0);
    step(1, T_IDLE, 0, 2, 32'h0, 32'hCAFE_F00D);
    stall = 1'b1;
    step(1, T_NSEQ, 0, 2, 32'h30, 32'h0);
    check("stall_nacc", HRDATA, 32'd0);
    stall = 1'b0;
    step(1, T_NSEQ, 0, 2, 32'h30, 32'h0);
    check("stall_acc", HRDATA, 32'hCAFE_F00D);

    // BUSY mid-burst writes nothing; HSEL low also ignored
    step(1, T_NSEQ, 1, 2, 32'h44, 32'h0);
    step(1, T_NSEQ, 1, 2, 32'h40, 32'h4444_4444);
    step(1, T_BUSY, 1, 2, 32'h44, 32'h4040_4040);
    check("busy_okay", {30'd0, HREADYOUT, HRESP}, 32'b10);
    step(0, T_NSEQ, 1, 2, 32'h44, 32'hBADB_AD00);
    step(1, T_NSEQ, 0, 2, 32'h44, 32'h5555_5555);
    check("busy_nowr", HRDATA, 32'h4444_4444);
    step(1, T_NSEQ, 0, 2, 32'h40, 32'h0);
    check("busy_first", HRDATA, 32'h4040_4040);
    step(1, T_IDLE, 0, 2, 32'h0, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
